// File: rtl/rx_control_if.sv
// Signal bundle between the UART receive timing controller and its line/data-path neighbours.
// The master drives line and frame configuration; the slave returns sample timing strobes.
interface rx_control_if #(
  parameter int unsigned BAUD_W = 20
);
  logic              rx;
  logic              bit8;
  logic              pen;
  logic [BAUD_W-1:0] baud;
  logic              btu;
  logic              done;
  logic              start;

  modport master (output rx, bit8, pen, baud, input btu, done, start);
  modport slave  (input rx, bit8, pen, baud, output btu, done, start);
endinterface

// File: rtl/rx_control.sv
// UART receive timing controller: start-bit detection and mid-bit sample strobes.
// Optional macro RXC_FALSE_START_EN: a start bit not still low at its sample point is dropped.
module rx_control #(
  parameter int unsigned BAUD_W = 20
) (
  input logic         clk,
  input logic         reset,
  rx_control_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StStart, StData} state_e;

  state_e            state_q;
  logic              start_q;
  logic [BAUD_W-1:0] tm_cnt_q;
  logic [3:0]        bit_cnt_q;
  logic [BAUD_W-1:0] baud_q;
  logic              bit8_q;
  logic              pen_q;

  logic [BAUD_W-1:0] target_raw;
  logic [BAUD_W-1:0] target;
  logic [3:0]        frame_last;
  logic              tick;
  logic              fin;

  // Half a bit period while centring on the start bit, a full period afterwards.
  always_comb begin
    target_raw = (state_q == StStart) ? (baud_q >> 1) : baud_q;
    target     = (target_raw == '0) ? BAUD_W'(1) : target_raw;
    frame_last = 4'd8 + {3'b000, bit8_q} + {3'b000, pen_q};
    tick       = (state_q != StIdle) && (tm_cnt_q == target - BAUD_W'(1));
    fin        = tick && (state_q == StData) && (bit_cnt_q == frame_last);
  end

  assign bus.btu   = tick;
  assign bus.done  = fin;
  assign bus.start = start_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      tm_cnt_q  <= '0;
      bit_cnt_q <= '0;
      baud_q    <= '0;
      bit8_q    <= 1'b0;
      pen_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tm_cnt_q  <= '0;
          bit_cnt_q <= '0;
          if (!bus.rx) begin
            state_q <= StStart;
            start_q <= 1'b1;
            baud_q  <= bus.baud;
            bit8_q  <= bus.bit8;
            pen_q   <= bus.pen;
          end
        end
        StStart: begin
          if (tick) begin
            tm_cnt_q <= '0;
`ifdef RXC_FALSE_START_EN
            if (bus.rx) begin
              state_q   <= StIdle;
              start_q   <= 1'b0;
              bit_cnt_q <= '0;
            end else begin
              state_q   <= StData;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
`else
            state_q   <= StData;
            bit_cnt_q <= bit_cnt_q + 4'd1;
`endif
          end else begin
            tm_cnt_q <= tm_cnt_q + BAUD_W'(1);
          end
        end
        StData: begin
          if (tick) begin
            tm_cnt_q <= '0;
            if (fin) begin
              state_q   <= StIdle;
              start_q   <= 1'b0;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else begin
            tm_cnt_q <= tm_cnt_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          start_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_control.sv
// Bench for rx_control: directed frames plus random line activity against a frame-schedule model.
module tb_rx_control;
  localparam int unsigned BaudW = 20;

  logic clk = 1'b0;
  logic reset;

  rx_control_if #(.BAUD_W(BaudW)) bus ();

  rx_control #(.BAUD_W(BaudW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: a frame is a schedule of sample points counted in cycles since frame entry.
  bit m_act = 1'b0;
  int m_k, m_half, m_per, m_n;

  // Observations of DUT outputs, reset each time start rises.
  bit prev_start = 1'b0;
  int obs_k, obs_first, obs_nbtu, obs_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Which sample point (1-based) falls on cycle k of the frame, or 0 if none.
  function automatic int sample_no(int k);
    if (k == m_half) return 1;
    if (k > m_half && ((k - m_half) % m_per) == 0) return 1 + (k - m_half) / m_per;
    return 0;
  endfunction

  task automatic step();
    int j;
    int unsigned b;
    @(posedge clk);
    if (!reset) begin
      m_act = 1'b0;
    end else if (m_act) begin
      j = sample_no(m_k);
      if (j == m_n) m_act = 1'b0;
`ifdef RXC_FALSE_START_EN
      else if (j == 1 && bus.rx) m_act = 1'b0;
`endif
      else m_k++;
    end else if (!bus.rx) begin
      b      = bus.baud;
      m_act  = 1'b1;
      m_k    = 1;
      m_half = ((b >> 1) == 0) ? 1 : int'(b >> 1);
      m_per  = (b == 0) ? 1 : int'(b);
      m_n    = 9 + int'(bus.bit8) + int'(bus.pen);
    end
    #1;
    j = m_act ? sample_no(m_k) : 0;
    check("start", bus.start, m_act);
    check("btu", bus.btu, j != 0);
    check("done", bus.done, (j != 0) && (j == m_n));
    if (bus.start && !prev_start) begin
      obs_k = 1; obs_first = 0; obs_nbtu = 0; obs_done = 0;
    end else if (bus.start) begin
      obs_k++;
    end
    if (bus.btu) begin
      obs_nbtu++;
      if (obs_first == 0) obs_first = obs_k;
    end
    if (bus.done) obs_done = obs_k;
    prev_start = bus.start;
  endtask

  task automatic run_to_idle(input int budget);
    int n = 0;
    while (m_act && n < budget) begin
      step();
      n++;
    end
    if (m_act) check("timeout", 0, 1);
  endtask

  // Full frame with rx held low; optional mid-frame configuration change after 200 cycles.
  task automatic frame(input int baud, input bit b8, input bit p, input int nb, input int new_baud);
    int half;
    half     = ((baud >> 1) == 0) ? 1 : (baud >> 1);
    bus.baud = BaudW'(baud);
    bus.bit8 = b8;
    bus.pen  = p;
    bus.rx   = 1'b0;
    step();
    for (int i = 0; i < 200 && m_act; i++) step();
    if (new_baud >= 0) begin
      bus.baud = BaudW'(new_baud);
      bus.bit8 = ~b8;
      bus.pen  = ~p;
    end
    run_to_idle(20000);
    bus.rx = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("first_btu", obs_first, half);
    check("nbtu", obs_nbtu, nb);
    check("done_at", obs_done, half + (nb - 1) * baud);
    check("start_low", bus.start, 0);
  endtask

  initial begin
    reset    = 1'b0;
    bus.rx   = 1'b1;
    bus.bit8 = 1'b0;
    bus.pen  = 1'b0;
    bus.baud = BaudW'(109);
    step();
    check("rst_start", bus.start, 0);
    check("rst_btu", bus.btu, 0);
    check("rst_done", bus.done, 0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) step();

    frame(109, 1'b0, 1'b0, 9, -1);
    frame(109, 1'b1, 1'b1, 11, -1);
    frame(109, 1'b1, 1'b0, 10, -1);
    frame(109, 1'b0, 1'b1, 10, -1);

    // Baud and format changes mid-frame must not disturb the frame in flight.
    frame(109, 1'b0, 1'b0, 9, 20);
    frame(20, 1'b0, 1'b0, 9, -1);

    // Start bit that is only 10 clocks long.
    bus.baud = BaudW'(109);
    bus.rx   = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.rx = 1'b1;
    run_to_idle(20000);
    step();
`ifdef RXC_FALSE_START_EN
    check("fs_nbtu", obs_nbtu, 1);
    check("fs_done", obs_done, 0);
`else
    check("fs_nbtu", obs_nbtu, 9);
    check("fs_done", obs_done, 926);
`endif
    frame(109, 1'b0, 1'b0, 9, -1);

    // Reset in the middle of the data bits.
    bus.rx = 1'b0;
    for (int i = 0; i < 300; i++) step();
    reset = 1'b0;
    step();
    check("mid_rst_start", bus.start, 0);
    check("mid_rst_btu", bus.btu, 0);
    check("mid_rst_done", bus.done, 0);
    reset  = 1'b1;
    bus.rx = 1'b1;
    step();
    frame(109, 1'b0, 1'b0, 9, -1);

    // Random line activity, configuration churn and occasional resets.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(7) == 0) bus.rx = ~bus.rx;
      if ($urandom_range(49) == 0) bus.baud = BaudW'($urandom_range(30));
      if ($urandom_range(29) == 0) bus.bit8 = 1'($urandom_range(1));
      if ($urandom_range(29) == 0) bus.pen = 1'($urandom_range(1));
      reset = ($urandom_range(1999) != 0);
      step();
    end
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
